// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: synchroniser, debounce, and press/release/long/repeat pulses.
// Two pulse ports are named release_pulse and repeat_pulse because "release" and "repeat" are reserved words.
module button_conditioner #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 20,
   parameter int LONG_CYCLES   = 50,
   parameter int REPEAT_CYCLES = 10,
   parameter int REPEAT_EN     = 1,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] pb,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] long_press,
   output logic [N-1:0] repeat_pulse
);

   localparam int CW   = $clog2(STABLE_CYCLES + 1);
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [CW-1:0] STABLE_TERM = CW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_TERM   = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REPEAT_TERM = HW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} hold_state_e;

   logic [N-1:0]   pb_fix;
   logic [N-1:0]   toggle;
   logic [N-1:0]   s1_q, s1_d;
   logic [N-1:0]   s2_q, s2_d;
   logic [N-1:0]   level_q, level_d;
   logic [N-1:0]   press_q, press_d;
   logic [N-1:0]   release_q, release_d;
   logic [N-1:0]   long_q, long_d;
   logic [N-1:0]   repeat_q, repeat_d;
   logic [CW-1:0]  deb_cnt_q [N];
   logic [CW-1:0]  deb_cnt_d [N];
   logic [HW-1:0]  hold_cnt_q [N];
   logic [HW-1:0]  hold_cnt_d [N];
   hold_state_e    state_q [N];
   hold_state_e    state_d [N];

   always_comb begin
      pb_fix    = (ACTIVE_LOW != 0) ? ~pb : pb;
      s1_d      = pb_fix;
      s2_d      = s1_q;
      toggle    = '0;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      repeat_d  = '0;
      for (int i = 0; i < N; i++) begin
         deb_cnt_d[i]  = '0;
         hold_cnt_d[i] = hold_cnt_q[i];
         state_d[i]    = state_q[i];

         if (s2_q[i] != level_q[i]) begin
            if (deb_cnt_q[i] == STABLE_TERM) begin
               toggle[i]  = 1'b1;
               level_d[i] = ~level_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
            end
         end

         // A debounced fall wins over any long/repeat event due in the same cycle.
         if (toggle[i] && level_q[i]) begin
            state_d[i]    = ST_IDLE;
            hold_cnt_d[i] = '0;
            release_d[i]  = 1'b1;
         end else if (toggle[i]) begin
            state_d[i]    = ST_HELD;
            hold_cnt_d[i] = '0;
            press_d[i]    = 1'b1;
         end else begin
            case (state_q[i])
               ST_HELD: begin
                  if (hold_cnt_q[i] == LONG_TERM) begin
                     long_d[i]     = 1'b1;
                     hold_cnt_d[i] = '0;
                     state_d[i]    = ST_REPEAT;
                  end else begin
                     hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (REPEAT_EN != 0) begin
                     if (hold_cnt_q[i] == REPEAT_TERM) begin
                        repeat_d[i]   = 1'b1;
                        hold_cnt_d[i] = '0;
                     end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         repeat_q  <= '0;
         for (int i = 0; i < N; i++) begin
            deb_cnt_q[i]  <= '0;
            hold_cnt_q[i] <= '0;
            state_q[i]    <= ST_IDLE;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         for (int i = 0; i < N; i++) begin
            deb_cnt_q[i]  <= deb_cnt_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
            state_q[i]    <= state_d[i];
         end
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance share one stimulus stream
// and are both checked every cycle against expected pulse timelines derived by hand from the timing rules.
module tb_button_conditioner;
   localparam int N  = 2;
   localparam int ST = 4;
   localparam int LG = 10;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pb;
   logic [N-1:0] pb_n;
   logic [N-1:0] level_a, press_a, rel_a, lp_a, rpt_a;
   logic [N-1:0] level_b, press_b, rel_b, lp_b, rpt_b;

   always #5 clk = ~clk;
   assign pb_n = ~pb;

   button_conditioner #(.N(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP),
                        .REPEAT_EN(1), .ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst(rst), .pb(pb), .level(level_a), .press(press_a),
      .release_pulse(rel_a), .long_press(lp_a), .repeat_pulse(rpt_a));

   button_conditioner #(.N(N), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP),
                        .REPEAT_EN(1), .ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst(rst), .pb(pb_n), .level(level_b), .press(press_b),
      .release_pulse(rel_b), .long_press(lp_b), .repeat_pulse(rpt_b));

   typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT, EV_CLEAR} ev_e;
   typedef struct {logic [N-1:0] pb; logic rst; int len;} seg_t;
   typedef struct {int cyc; int ch; ev_e kind;} ev_t;

   seg_t             segs[$];
   ev_t              evs[$];
   logic [5*N-1:0]   exp_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;

   task automatic add_seg(input logic [N-1:0] p, input logic r, input int len);
      seg_t s;
      s.pb = p; s.rst = r; s.len = len;
      segs.push_back(s);
   endtask

   task automatic add_ev(input int cyc, input int ch, input ev_e kind);
      ev_t e;
      e.cyc = cyc; e.ch = ch; e.kind = kind;
      evs.push_back(e);
   endtask

   task automatic check_outputs(input string name, input int cyc);
      logic [5*N-1:0] exp_v;
      logic [5*N-1:0] got_a;
      logic [5*N-1:0] got_b;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s cycle %0d: scoreboard empty", name, cyc);
         return;
      end
      exp_v = exp_q.pop_front();
      got_a = {level_a, press_a, rel_a, lp_a, rpt_a};
      got_b = {level_b, press_b, rel_b, lp_b, rpt_b};
      if (got_a === exp_v) n_pass++;
      else $display("FAIL %s active_high cycle %0d: got %b expected %b (level,press,release,long,repeat)",
                    name, cyc, got_a, exp_v);
      n_checks++;
      if (got_b === exp_v) n_pass++;
      else $display("FAIL %s active_low cycle %0d: got %b expected %b (level,press,release,long,repeat)",
                    name, cyc, got_b, exp_v);
   endtask

   // Cycle c drives pb at a negedge; the next posedge is edge c; outputs after edge c are compared.
   task automatic run_scenario(input string name);
      int             total;
      int             c;
      logic [N-1:0]   lvl;
      logic [N-1:0]   pr, rl, lp, rp;
      logic [5*N-1:0] exp_vec[];
      total = 0;
      foreach (segs[i]) total += segs[i].len;
      exp_vec = new[total];
      lvl = '0;
      for (int k = 0; k < total; k++) begin
         pr = '0; rl = '0; lp = '0; rp = '0;
         foreach (evs[i]) begin
            if (evs[i].cyc == k) begin
               case (evs[i].kind)
                  EV_PRESS:   begin pr[evs[i].ch] = 1'b1; lvl[evs[i].ch] = 1'b1; end
                  EV_RELEASE: begin rl[evs[i].ch] = 1'b1; lvl[evs[i].ch] = 1'b0; end
                  EV_LONG:    lp[evs[i].ch] = 1'b1;
                  EV_REPEAT:  rp[evs[i].ch] = 1'b1;
                  EV_CLEAR:   lvl[evs[i].ch] = 1'b0;
                  default: ;
               endcase
            end
         end
         exp_vec[k] = {lvl, pr, rl, lp, rp};
      end
      c = 0;
      foreach (segs[i]) begin
         for (int k = 0; k < segs[i].len; k++) begin
            pb  = segs[i].pb;
            rst = segs[i].rst;
            exp_q.push_back(exp_vec[c]);
            @(posedge clk);
            @(negedge clk);
            check_outputs(name, c);
            c++;
         end
      end
      segs.delete();
      evs.delete();
   endtask

   initial begin
      rst = 1'b1;
      pb  = '0;
      @(negedge clk);

      add_seg(2'b00, 1'b1, 3);
      add_seg(2'b00, 1'b0, 3);
      run_scenario("reset");

      add_seg(2'b01, 1'b0, 8);
      add_seg(2'b00, 1'b0, 12);
      add_ev(5, 0, EV_PRESS);
      add_ev(13, 0, EV_RELEASE);
      run_scenario("clean_press");

      add_seg(2'b01, 1'b0, 1);
      add_seg(2'b00, 1'b0, 1);
      add_seg(2'b01, 1'b0, 1);
      add_seg(2'b00, 1'b0, 1);
      add_seg(2'b01, 1'b0, 3);
      add_seg(2'b00, 1'b0, 9);
      run_scenario("bounce");

      // Fall lands on the fifth repeat slot (cycle 30): release only.
      add_seg(2'b10, 1'b0, 25);
      add_seg(2'b00, 1'b0, 15);
      add_ev(5, 1, EV_PRESS);
      add_ev(15, 1, EV_LONG);
      add_ev(18, 1, EV_REPEAT);
      add_ev(21, 1, EV_REPEAT);
      add_ev(24, 1, EV_REPEAT);
      add_ev(27, 1, EV_REPEAT);
      add_ev(30, 1, EV_RELEASE);
      run_scenario("long_repeat");

      // Both channels together; fall lands on the long_press slot.
      add_seg(2'b11, 1'b0, 10);
      add_seg(2'b00, 1'b0, 12);
      add_ev(5, 0, EV_PRESS);
      add_ev(5, 1, EV_PRESS);
      add_ev(15, 0, EV_RELEASE);
      add_ev(15, 1, EV_RELEASE);
      run_scenario("dual_long_edge");

      add_seg(2'b01, 1'b0, 22);
      add_seg(2'b01, 1'b1, 1);
      add_seg(2'b01, 1'b0, 19);
      add_seg(2'b00, 1'b0, 13);
      add_ev(5, 0, EV_PRESS);
      add_ev(15, 0, EV_LONG);
      add_ev(18, 0, EV_REPEAT);
      add_ev(21, 0, EV_REPEAT);
      add_ev(22, 0, EV_CLEAR);
      add_ev(28, 0, EV_PRESS);
      add_ev(38, 0, EV_LONG);
      add_ev(41, 0, EV_REPEAT);
      add_ev(44, 0, EV_REPEAT);
      add_ev(47, 0, EV_RELEASE);
      run_scenario("reset_mid_hold");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
